// File: rtl/ram_8_if.sv
// Bus bundle for the 8-word scratch RAM.
// The master drives the access strobes, address and write data.
// The slave returns the registered read data.
interface ram_8_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();

    logic              en;
    logic              w;
    logic              r;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    modport master (
        output en,
        output w,
        output r,
        output add,
        output d_in,
        input  d_out
    );

    modport slave (
        input  en,
        input  w,
        input  r,
        input  add,
        input  d_in,
        output d_out
    );

endinterface

// File: rtl/ram_8.sv
// Single-port synchronous scratch RAM with a registered read port.
// A write and a read may share one cycle. In that case the read returns
// the incoming write data (write-through), so stale data is never seen.
// Reset clears both the array and the output register.
module ram_8 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_8_if.slave    bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] d_out_q;

    // Storage and read register: reset wins, then enable, then the strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            d_out_q <= '0;
        end else if (bus.en) begin
            if (bus.w) begin
                mem[bus.add] <= bus.d_in;
            end
            if (bus.r) begin
                d_out_q <= bus.w ? bus.d_in : mem[bus.add];
            end
        end
    end

    assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_ram_8.sv
// Randomised and directed bench for ram_8.
// It keeps an array-based reference of the memory contents and the read
// register, and checks d_out one time step after each rising edge.
module tb_ram_8;

    logic clk;
    logic rst_n;

    ram_8_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    ram_8 #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] model_mem [8];
    logic [15:0] model_dout;

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one access:
    //   - drive the inputs on the falling edge,
    //   - update the reference at the rising edge,
    //   - settle for one time step before returning.
    task automatic drive(input logic rn, input logic en_v, input logic w_v,
                         input logic r_v, input logic [2:0] a,
                         input logic [15:0] d);
        @(negedge clk);
        rst_n    = rn;
        bus.en   = en_v;
        bus.w    = w_v;
        bus.r    = r_v;
        bus.add  = a;
        bus.d_in = d;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
            model_dout = 16'h0000;
        end else if (en_v) begin
            if (r_v) model_dout = w_v ? d : model_mem[a];
            if (w_v) model_mem[a] = d;
        end
        #1;
    endtask

    // Reset, then read every word back as zero
    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 16'h1234);
        vectors++;
        if (bus.d_out !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_dout: got %h expected 0000", bus.d_out);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 3'(k), 16'hDEAD);
            vectors++;
            if (bus.d_out !== 16'h0000) begin
                miscompares++;
                $display("[TB] FAIL reset_read[%0d]: got %h expected 0000", k, bus.d_out);
            end
        end
    endtask

    // Simultaneous write and read returns the written data at once
    task automatic test_write_through();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 3'(k), 16'(k + 1));
            vectors++;
            if (bus.d_out !== 16'(k + 1)) begin
                miscompares++;
                $display("[TB] FAIL write_through[%0d]: got %h expected %h", k, bus.d_out, 16'(k + 1));
            end
        end
    endtask

    // With enable low, nothing changes; read word 5 afterwards to confirm
    task automatic test_enable_low();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'd9);
        vectors++;
        if (bus.d_out !== 16'd8) begin
            miscompares++;
            $display("[TB] FAIL enable_low_hold: got %h expected 0008", bus.d_out);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
        vectors++;
        if (bus.d_out !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL enable_low_mem5: got %h expected 0006", bus.d_out);
        end
    endtask

    // Overwrite word 4, then confirm it with a pure read
    task automatic test_overwrite();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 16'd10);
        vectors++;
        if (bus.d_out !== 16'd10) begin
            miscompares++;
            $display("[TB] FAIL overwrite_through: got %h expected 000a", bus.d_out);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 16'h0000);
        vectors++;
        if (bus.d_out !== 16'd10) begin
            miscompares++;
            $display("[TB] FAIL overwrite_read: got %h expected 000a", bus.d_out);
        end
    endtask

    // A pure read, then a pure write that must hold d_out, then a read-back
    task automatic test_pure_rw();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
        vectors++;
        if (bus.d_out !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL pure_read: got %h expected 0006", bus.d_out);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 16'hFFFF);
        vectors++;
        if (bus.d_out !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL pure_write_hold: got %h expected 0006", bus.d_out);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0000);
        vectors++;
        if (bus.d_out !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL pure_write_read: got %h expected ffff", bus.d_out);
        end
    endtask

    // A write that coincides with reset is discarded
    task automatic test_reset_during_write();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'hABCD);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 16'h0000);
        vectors++;
        if (bus.d_out !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_during_write: got %h expected 0000", bus.d_out);
        end
    endtask

    // Random traffic (with occasional resets) checked against the reference
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic rn;
            rn = ($urandom_range(0, 39) != 0);
            drive(rn, 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 16'($urandom));
            vectors++;
            if (bus.d_out !== model_dout) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", n, bus.d_out, model_dout);
            end
        end
        // Sweep every word once so stored contents are compared directly
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 3'(k), 16'h0000);
            vectors++;
            if (bus.d_out !== model_mem[k]) begin
                miscompares++;
                $display("[TB] FAIL random_sweep[%0d]: got %h expected %h", k, bus.d_out, model_mem[k]);
            end
        end
    endtask

    // Test sequence
    initial begin
        rst_n    = 1'b1;
        bus.en   = 1'b0;
        bus.w    = 1'b0;
        bus.r    = 1'b0;
        bus.add  = 3'd0;
        bus.d_in = 16'h0000;
        for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
        model_dout = 16'h0000;

        test_reset();
        test_write_through();
        test_enable_low();
        test_overwrite();
        test_pure_rw();
        test_reset_during_write();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
